// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 ALU issue stage: ALU opcode
// encoding, RV32I major opcodes, issue FSM states and the decoded bundle.
package msrv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic        illegal;
  } alu_bundle_t;

endpackage

// File: rtl/msrv32_alu_issue_if.sv
// Issue-to-ALU bundle with valid/ready flow control; the issue stage is master.
interface msrv32_alu_issue_if;
  logic        valid_out;
  logic        ready_in;
  logic [3:0]  opcode_out;
  logic [31:0] op_1_out;
  logic [31:0] op_2_out;
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic        illegal_out;

  modport master (
    output valid_out, opcode_out, op_1_out, op_2_out, rd_addr_out, wr_en_out, illegal_out,
    input  ready_in
  );

  modport slave (
    input  valid_out, opcode_out, op_1_out, op_2_out, rd_addr_out, wr_en_out, illegal_out,
    output ready_in
  );
endinterface

// File: rtl/msrv32_alu_decode.sv
// Combinational RV32I decode of OP/OP-IMM/LUI/AUIPC into an ALU opcode,
// operand pair and write-back control; anything else is flagged illegal.
module msrv32_alu_decode
  import msrv32_pkg::*;
(
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_rs1_data,
  input  logic [31:0]  i_rs2_data,
  output alu_bundle_t  o_bundle
);

  logic [6:0]  w_major;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic        w_legal;
  logic        w_shift;
  logic [3:0]  w_opcode;
  logic [31:0] w_op_1;
  logic [31:0] w_op_2;

  assign w_major  = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_shift  = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    w_legal  = 1'b0;
    w_opcode = ALU_ADD;
    w_op_1   = '0;
    w_op_2   = '0;
    case (w_major)
      OPC_OP: begin
        w_legal  = (w_funct7 == 7'b0000000) ||
                   ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        w_opcode = {w_funct7[5], w_funct3};
        w_op_1   = i_rs1_data;
        w_op_2   = w_shift ? {27'b0, i_rs2_data[4:0]} : i_rs2_data;
      end
      OPC_OPIMM: begin
        w_op_1 = i_rs1_data;
        if (w_funct3 == 3'b001) begin
          w_legal  = (w_funct7 == 7'b0000000);
          w_opcode = {1'b0, w_funct3};
          w_op_2   = {27'b0, i_instr[24:20]};
        end else if (w_funct3 == 3'b101) begin
          w_legal  = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
          w_opcode = {i_instr[30], w_funct3};
          w_op_2   = {27'b0, i_instr[24:20]};
        end else begin
          w_legal  = 1'b1;
          w_opcode = {1'b0, w_funct3};
          w_op_2   = {{20{i_instr[31]}}, i_instr[31:20]};
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_op_2  = {i_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_op_1  = i_pc;
        w_op_2  = {i_instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Illegal encodings travel as an inert bundle: zero operands, no write-back.
  always_comb begin
    o_bundle.rd_addr = w_rd;
    o_bundle.illegal = !w_legal;
    o_bundle.wr_en   = w_legal && (w_rd != 5'd0);
    o_bundle.opcode  = w_legal ? w_opcode : ALU_ADD;
    o_bundle.op_1    = w_legal ? w_op_1 : 32'd0;
    o_bundle.op_2    = w_legal ? w_op_2 : 32'd0;
  end

endmodule

// File: rtl/msrv32_alu_issue.sv
// ALU issue stage: decodes one instruction per handshake into a single
// registered bundle with valid/ready flow control and flush.
module msrv32_alu_issue
  import msrv32_pkg::*;
(
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  input  logic [31:0]          instr_in,
  input  logic [31:0]          pc_in,
  input  logic                 instr_valid_in,
  output logic                 instr_ready_out,
  output logic [4:0]           rs1_addr_out,
  output logic [4:0]           rs2_addr_out,
  input  logic [31:0]          rs1_data_in,
  input  logic [31:0]          rs2_data_in,
  input  logic                 flush_in,
  msrv32_alu_issue_if.master   alu_bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  alu_bundle_t r_bundle;
  alu_bundle_t w_dec;
  logic        w_accept;
  logic        w_load;

  assign rs1_addr_out = instr_in[19:15];
  assign rs2_addr_out = instr_in[24:20];

  msrv32_alu_decode u_decode (
    .i_instr    (instr_in),
    .i_pc       (pc_in),
    .i_rs1_data (rs1_data_in),
    .i_rs2_data (rs2_data_in),
    .o_bundle   (w_dec)
  );

  assign alu_bus.valid_out = (r_state == ST_FULL);
  assign instr_ready_out   = !alu_bus.valid_out || alu_bus.ready_in;
  assign w_accept          = instr_valid_in && instr_ready_out;

  // Flush wins over everything, including an instruction accepted this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept && !flush_in) begin
          w_state_nxt = ST_FULL;
          w_load      = 1'b1;
        end
      end
      ST_FULL: begin
        if (flush_in) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_load = 1'b1;
        end else if (alu_bus.ready_in) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the bundle register is reset too, because its fields are visible outputs with defined reset values.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      r_bundle <= '0;
    end else if (w_load) begin
      r_bundle <= w_dec;
    end
  end

  assign alu_bus.opcode_out  = r_bundle.opcode;
  assign alu_bus.op_1_out    = r_bundle.op_1;
  assign alu_bus.op_2_out    = r_bundle.op_2;
  assign alu_bus.rd_addr_out = r_bundle.rd_addr;
  assign alu_bus.wr_en_out   = r_bundle.wr_en;
  assign alu_bus.illegal_out = r_bundle.illegal;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Directed bench for msrv32_alu_issue: decode vectors, backpressure,
// flush and asynchronous reset, checked against hand-computed values.
module tb_msrv32_alu_issue;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [4:0]  rs1_addr_out;
  logic [4:0]  rs2_addr_out;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic        flush_in;

  int n_checks = 0;
  int n_fail   = 0;

  msrv32_alu_issue_if alu_bus ();

  msrv32_alu_issue dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .instr_in             (instr_in),
    .pc_in                (pc_in),
    .instr_valid_in       (instr_valid_in),
    .instr_ready_out      (instr_ready_out),
    .rs1_addr_out         (rs1_addr_out),
    .rs2_addr_out         (rs2_addr_out),
    .rs1_data_in          (rs1_data_in),
    .rs2_data_in          (rs2_data_in),
    .flush_in             (flush_in),
    .alu_bus              (alu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Present one instruction, let it be accepted on the next edge, sample #1 after.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2);
    instr_in       = instr;
    pc_in          = pc;
    rs1_data_in    = d1;
    rs2_data_in    = d2;
    instr_valid_in = 1'b1;
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
  endtask

  task automatic check_bundle(input string tag, input logic v, input logic [3:0] opc,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic we, input logic ill);
    check({tag, "_valid"},  {31'b0, alu_bus.valid_out},   {31'b0, v});
    check({tag, "_opcode"}, {28'b0, alu_bus.opcode_out},  {28'b0, opc});
    check({tag, "_op1"},    alu_bus.op_1_out,             op1);
    check({tag, "_op2"},    alu_bus.op_2_out,             op2);
    check({tag, "_rd"},     {27'b0, alu_bus.rd_addr_out}, {27'b0, rd});
    check({tag, "_wr_en"},  {31'b0, alu_bus.wr_en_out},   {31'b0, we});
    check({tag, "_illegal"},{31'b0, alu_bus.illegal_out}, {31'b0, ill});
  endtask

  initial begin
    rst_n           = 1'b1;
    instr_in        = '0;
    pc_in           = '0;
    instr_valid_in  = 1'b0;
    rs1_data_in     = '0;
    rs2_data_in     = '0;
    flush_in        = 1'b0;
    alu_bus.ready_in = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    check_bundle("reset", 1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    check("reset_ready", {31'b0, instr_ready_out}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD x3,x1,x2
    instr_in = r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    #1;
    check("rs1_addr", {27'b0, rs1_addr_out}, 32'd1);
    check("rs2_addr", {27'b0, rs2_addr_out}, 32'd2);
    issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0, 32'd5, 32'd7);
    check_bundle("add", 1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);

    // SRAI x4,x1,3
    issue(i_type(12'b0100000_00011, 5'd1, 3'b101, 5'd4, 7'b0010011), 32'h0, 32'h8000_0000, 32'd0);
    check_bundle("srai", 1'b1, 4'b1101, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 1'b0);

    // SLLI with imm[11:5]=0100000 is illegal
    issue(i_type(12'b0100000_00010, 5'd1, 3'b001, 5'd4, 7'b0010011), 32'h0, 32'h1234, 32'd0);
    check_bundle("slli_bad", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd4, 1'b0, 1'b1);

    // AUIPC x5,0x12345 at pc 0x100
    issue(u_type(20'h12345, 5'd5, 7'b0010111), 32'h100, 32'hDEAD, 32'hBEEF);
    check_bundle("auipc", 1'b1, 4'b0000, 32'h100, 32'h1234_5000, 5'd5, 1'b1, 1'b0);

    // ADDI x0,x0,-1
    issue(i_type(12'hFFF, 5'd0, 3'b000, 5'd0, 7'b0010011), 32'h0, 32'd0, 32'd0);
    check_bundle("addi_x0", 1'b1, 4'b0000, 32'd0, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);

    // Idle cycle with ready_in=1 drains the stage
    @(posedge clk);
    #1;
    check("drain_valid", {31'b0, alu_bus.valid_out}, 32'd0);

    // SLL x6,x1,x2 uses only rs2[4:0]
    issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd6), 32'h0, 32'h0000_0011, 32'h0000_0025);
    check_bundle("sll", 1'b1, 4'b0001, 32'h11, 32'd5, 5'd6, 1'b1, 1'b0);

    // LUI x10,0xABCDE ignores rs1 data
    issue(u_type(20'hABCDE, 5'd10, 7'b0110111), 32'h40, 32'h1234, 32'h0);
    check_bundle("lui", 1'b1, 4'b0000, 32'd0, 32'hABCD_E000, 5'd10, 1'b1, 1'b0);

    // OP with funct7=0100000, funct3=100 is illegal
    issue(r_type(7'b0100000, 5'd2, 5'd1, 3'b100, 5'd12), 32'h0, 32'h5, 32'h6);
    check_bundle("xor_bad", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd12, 1'b0, 1'b1);

    // LW is outside the supported major opcodes
    issue(i_type(12'h004, 5'd1, 3'b010, 5'd11, 7'b0000011), 32'h0, 32'h5, 32'h6);
    check_bundle("load", 1'b1, 4'b0000, 32'd0, 32'd0, 5'd11, 1'b0, 1'b1);

    // SUB x7,x1,x2 then backpressure with XOR waiting upstream
    issue(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7), 32'h0, 32'd10, 32'd3);
    check_bundle("sub", 1'b1, 4'b1000, 32'd10, 32'd3, 5'd7, 1'b1, 1'b0);
    alu_bus.ready_in = 1'b0;
    instr_in       = r_type(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd8);
    rs1_data_in    = 32'hF0;
    rs2_data_in    = 32'hFF;
    instr_valid_in = 1'b1;
    #1;
    check("stall_ready0", {31'b0, instr_ready_out}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_bundle($sformatf("stall%0d", i), 1'b1, 4'b1000, 32'd10, 32'd3, 5'd7, 1'b1, 1'b0);
      check($sformatf("stall%0d_ready", i), {31'b0, instr_ready_out}, 32'd0);
    end
    alu_bus.ready_in = 1'b1;
    #1;
    check("release_ready", {31'b0, instr_ready_out}, 32'd1);
    @(posedge clk);
    #1;
    instr_valid_in = 1'b0;
    check_bundle("refill_xor", 1'b1, 4'b0100, 32'hF0, 32'hFF, 5'd8, 1'b1, 1'b0);

    // Flush while FULL and accepting OR x9: the OR must never appear
    instr_in       = r_type(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd9);
    rs1_data_in    = 32'h1;
    rs2_data_in    = 32'h2;
    instr_valid_in = 1'b1;
    flush_in       = 1'b1;
    #1;
    check("flush_ready", {31'b0, instr_ready_out}, 32'd1);
    @(posedge clk);
    #1;
    flush_in       = 1'b0;
    instr_valid_in = 1'b0;
    check("flush_valid0", {31'b0, alu_bus.valid_out}, 32'd0);
    @(posedge clk);
    #1;
    check("flush_valid1", {31'b0, alu_bus.valid_out}, 32'd0);

    // Asynchronous reset while FULL
    issue(r_type(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd13), 32'h0, 32'hF0F0, 32'h0FF0);
    check_bundle("and", 1'b1, 4'b0111, 32'hF0F0, 32'h0FF0, 5'd13, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_bundle("async_rst", 1'b0, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_alu_issue.md
# msrv32_alu_issue

Issue stage that sits in front of the msrv32 ALU: accepts one RV32I instruction per handshake, decodes OP, OP-IMM, LUI and AUIPC into the 4-bit ALU opcode, and selects the two operands from register-file read data, the immediate or the PC. The decoded bundle is held in a single output register with valid/ready flow control. Downstream, `opcode_out`, `op_1_out` and `op_2_out` drive the ALU's opcode and operand inputs, and `rd_addr_out`/`wr_en_out` travel with the result to write-back.

## Interface
- No parameters; widths fixed at XLEN=32.
- `ms_riscv32_mp_clk_in` in 1: clock, rising edge.
- `ms_riscv32_mp_rst_in` in 1: reset, asynchronous, active-low.
- `instr_in` in 32: instruction word.
- `pc_in` in 32: PC of `instr_in`.
- `instr_valid_in` in 1: upstream offers an instruction.
- `instr_ready_out` out 1: stage accepts this cycle.
- `rs1_addr_out`, `rs2_addr_out` out 5: combinational, `instr_in[19:15]` and `instr_in[24:20]`, driving register-file reads.
- `rs1_data_in`, `rs2_data_in` in 32: register-file read data, same cycle.
- `flush_in` in 1: discard the held entry.
- `valid_out` out 1: bundle valid.
- `ready_in` in 1: downstream accepts.
- `opcode_out` out 4: ALU opcode.
- `op_1_out`, `op_2_out` out 32: ALU operands.
- `rd_addr_out` out 5: destination register.
- `wr_en_out` out 1: write-back enable.
- `illegal_out` out 1: held entry is an unsupported or illegal encoding.

## Operation
- ALU opcode encoding:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011.
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- OP (0110011):
  - opcode = {funct7[5], funct3}.
  - Legal when funct7=0000000, or when funct7=0100000 with funct3 ∈ {000, 101}.
  - op_1 = rs1_data, op_2 = {27'b0, rs2_data[4:0]} for shifts, otherwise rs2_data.
- OP-IMM (0010011), non-shift:
  - opcode = {1'b0, funct3}.
  - op_2 = sign-extended imm[11:0].
- OP-IMM shifts:
  - SLLI legal only with imm[11:5]=0000000.
  - SRLI/SRAI legal with imm[11:5] ∈ {0000000, 0100000}; opcode = {imm[10], funct3}.
  - op_2 = {27'b0, shamt}.
- LUI: opcode ADD, op_1 = 0, op_2 = {imm[31:12], 12'b0}.
- AUIPC: opcode ADD, op_1 = pc_in, op_2 = {imm[31:12], 12'b0}.
- Any other major opcode, or an illegal funct7 field:
  - illegal_out=1, wr_en_out=0, opcode_out=0000, op_1_out=0, op_2_out=0.
  - The entry still occupies the stage and is handed off normally.
- wr_en_out = legal AND rd≠0.
- Two-state FSM:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on (valid_out & ready_in & no accept) or flush_in.
  - FULL→FULL on simultaneous hand-off and accept.

## Timing
- Reset state: EMPTY. valid_out, illegal_out, wr_en_out = 0; opcode_out = 0000; operands, rd_addr_out = 0.
- instr_ready_out = !valid_out | ready_in, combinational. It is not gated by flush_in.
- Accept = instr_valid_in & instr_ready_out. The bundle appears on the outputs the next cycle (latency 1). Back-to-back throughput is 1/cycle.
- While valid_out=1 and ready_in=0, all outputs hold stable.
- flush_in:
  - Clears valid_out next cycle and overrides a same-cycle accept; the new instruction is dropped.
  - Upstream must treat an accept coinciding with flush_in as discarded.
- rs*_addr_out follow instr_in combinationally, independent of handshake.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous); any held entry is lost.

## Structure
- `msrv32_pkg` holds:
  - ALU opcode localparams (ALU_ADD … ALU_AND).
  - Major-opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC).
  - The FSM state encoding.
- `msrv32_alu_decode` is the natural sub-module: purely combinational instruction→{opcode, op_1, op_2, wr_en, illegal}. The top holds the FSM and the output register.

## Test plan
- Reset, then ADD x3,x1,x2 with rs1=5, rs2=7, ready_in=1 → next cycle valid_out=1, opcode 0000, op_1=5, op_2=7, rd=3, wr_en=1.
- SRAI x4,x1,3 (imm[11:5]=0100000) → opcode 1101, op_2=3. SLLI with imm[11:5]=0100000 → illegal_out=1, wr_en=0.
- AUIPC x5,0x12345 with pc=0x100 → opcode 0000, op_1=0x100, op_2=0x12345000. ADDI x0,x0,-1 → op_2=0xFFFFFFFF, wr_en=0.
- Backpressure: ready_in=0 for 3 cycles with a held SUB → outputs stable, instr_ready_out=0. Releasing ready_in with a new valid input hands off and refills in the same cycle.
- flush_in while FULL and accepting → valid_out=0 next cycle; the new instruction never appears.
- Reset asserted mid-stream while FULL → valid_out=0 immediately, without waiting for a clock edge.
